id_fsm_recognizer: RTL and testbench



---
 rtl/id_fsm_recognizer.sv | 108 ++++++++++
 tb/tb_id_fsm_recognizer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/id_fsm_recognizer.sv
// Identifier recognizer: letters+ digits+ over an ASCII byte stream.
// Moore match flag, one character per clock.
package id_fsm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LET  = 2'b01,
    S_DIG  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    C_OTHER = 2'b00,
    C_LET   = 2'b01,
    C_DIG   = 2'b10
  } cls_t;

  function automatic cls_t classify(
    input logic [7:0] c
  );
    cls_t k;
    k = C_OTHER;
    unique case (1'b1)
      (c >= 8'd65 && c <= 8'd90):  k = C_LET;
      (c >= 8'd97 && c <= 8'd122): k = C_LET;
      (c >= 8'd48 && c <= 8'd57):  k = C_DIG;
      default:                     k = C_OTHER;
    endcase
    return k;
  endfunction

  // A digit only extends a candidate that
  // already has letters; letters always
  // (re)start a candidate.
  function automatic state_t advance(
    input state_t s,
    input cls_t   k
  );
    state_t n;
    n = S_IDLE;
    case (s)
      S_IDLE: begin
        if (k == C_LET) n = S_LET;
        else            n = S_IDLE;
      end
      S_LET: begin
        if (k == C_LET)      n = S_LET;
        else if (k == C_DIG) n = S_DIG;
        else                 n = S_IDLE;
      end
      S_DIG: begin
        if (k == C_DIG)      n = S_DIG;
        else if (k == C_LET) n = S_LET;
        else                 n = S_IDLE;
      end
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

endpackage

module id_fsm
  import id_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char,
  output logic       out
);

  state_t state;
  state_t nxt;
  cls_t   cls;

  // Character class and next state.
  always_comb begin
    cls = classify(char);
    nxt = advance(state, cls);
  end

  // State register with registered match flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      out   <= 1'b0;
    end else begin
      state <= nxt;
      out   <= (nxt == S_DIG);
    end
  end

endmodule

module id_fsm_recognizer (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char,
  output logic       out
);

  id_fsm u_fsm (
    .clk   (clk),
    .reset (reset),
    .char  (char),
    .out   (out)
  );

endmodule

// File: tb/tb_id_fsm_recognizer.sv
// Bench for id_fsm_recognizer: directed plan
// plus random stream against a history model.
module tb_id_fsm_recognizer;

  logic       clk;
  logic       reset;
  logic [7:0] ch;
  logic       out_w;

  int checks;
  int errors;

  byte unsigned hist[$];

  id_fsm_recognizer dut (
    .clk   (clk),
    .reset (reset),
    .char  (ch),
    .out   (out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_letter(byte unsigned c);
    return (c >= 65 && c <= 90) || (c >= 97 && c <= 122);
  endfunction

  function automatic bit is_digit(byte unsigned c);
    return (c >= 48 && c <= 57);
  endfunction

  // Match iff history ends with >=1 digit
  // directly preceded by a letter.
  function automatic logic model_out();
    int i;
    int nd;
    i = hist.size() - 1;
    nd = 0;
    while (i >= 0 && is_digit(hist[i])) begin
      nd++;
      i--;
    end
    if (nd == 0 || i < 0) return 1'b0;
    return is_letter(hist[i]) ? 1'b1 : 1'b0;
  endfunction

  task automatic step(
    input byte unsigned c,
    input logic         r,
    input string        tag
  );
    logic exp;
    @(negedge clk);
    ch = c;
    reset = r;
    @(posedge clk);
    #1;
    if (r) hist.delete();
    else   hist.push_back(c);
    exp = model_out();
    checks++;
    assert (out_w === exp) else begin
      errors++;
      $error("FAIL %s char=%0d obs=%b exp=%b",
             tag, c, out_w, exp);
    end
  endtask

  task automatic feed(input string s, input string tag);
    for (int i = 0; i < s.len(); i++)
      step(s[i], 1'b0, tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    ch = 8'd0;

    step(8'd0, 1'b1, "reset");
    step(8'd0, 1'b1, "reset2");

    step("0", 1'b0, "lead_dig");
    step(8'h1F, 1'b0, "lead_ctl");
    step("0", 1'b0, "lead_dig2");

    step(8'd0, 1'b1, "rst_a");
    feed("aaa00a1", "aaa00a1");

    step(8'd0, 1'b1, "rst_b");
    feed("Zz9", "Zz9");
    step(8'd47, 1'b0, "slash");
    step("9", 1'b0, "after_slash");

    step(8'd0, 1'b1, "rst_c");
    step("a", 1'b0, "bnd_a1");
    step(8'd58, 1'b0, "colon");
    step("1", 1'b0, "colon_dig");
    step("a", 1'b0, "bnd_a2");
    step(8'd64, 1'b0, "at");
    step("1", 1'b0, "at_dig");
    step("a", 1'b0, "bnd_a3");
    step(8'd96, 1'b0, "btick");
    step("1", 1'b0, "btick_dig");
    step("a", 1'b0, "bnd_a4");
    step(8'd123, 1'b0, "lbrace");
    step("1", 1'b0, "lbrace_dig");
    feed("Az", "edge_let");
    step("0", 1'b0, "dig0");
    step("9", 1'b0, "dig9");
    step("Z", 1'b0, "let_Z");
    step("z", 1'b0, "let_z");

    feed("b5", "b5");
    step("6", 1'b1, "rst_mid");
    step("6", 1'b0, "post_rst");

    step("x", 1'b0, "long_x");
    for (int i = 0; i < 20; i++)
      step(8'(48 + (i % 10)), 1'b0, "long_dig");
    step(8'd255, 1'b0, "long_255");

    for (int i = 0; i < 400; i++) begin
      int sel;
      byte unsigned c;
      sel = $urandom_range(0, 9);
      if (sel < 2)
        c = 8'($urandom_range(65, 90));
      else if (sel < 4)
        c = 8'($urandom_range(97, 122));
      else if (sel < 8)
        c = 8'($urandom_range(48, 57));
      else
        c = 8'($urandom_range(0, 255));
      step(c, ($urandom_range(0, 39) == 0),
           "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
